// File: rtl/vga_rx_capture.sv
// vga_rx_capture: recovers an X/Y pixel stream from HS/VS/BLK/RGB and locks on the expected active format
module vga_rx_capture #(
  parameter int H_ACT = 800,
  parameter int V_ACT = 480,
  parameter int LOCK_FRAMES = 2,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLK,
  input  logic [23:0] VGA_RGB,
  output logic        Pix_Valid,
  output logic [23:0] Pix_Data,
  output logic [10:0] Pix_X,
  output logic [10:0] Pix_Y,
  output logic        Frame_Start,
  output logic        Frame_End,
  output logic        Locked,
  output logic [10:0] Meas_Width,
  output logic [10:0] Meas_Height,
  output logic        Err
);
  localparam logic [10:0] HW = 11'(H_ACT);
  localparam logic [10:0] VH = 11'(V_ACT);
  localparam logic [10:0] CMAX = 11'h7ff;
  localparam logic [2:0] LF = 3'(LOCK_FRAMES);
  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
  state_t state, state_n;
  logic hs1, hs2, vs1, vs2, blk1, blk2;
  logic [23:0] rgb1, rgb2;
  logic [10:0] x_cnt, line_cnt, x_inc, l_inc, h_fin;
  logic [2:0] good, good_n;
  logic frame_bad, hs_seen, hs_a2, vs_rise, de_fall, w_bad, bad, pix_ok;
  assign hs_a2 = hs2 == HS_POL;
  assign vs_rise = (vs1 == VS_POL) && (vs2 != VS_POL);
  assign de_fall = !blk1 && blk2;
  assign x_inc = x_cnt == CMAX ? x_cnt : x_cnt + 11'd1;
  assign l_inc = line_cnt == CMAX ? line_cnt : line_cnt + 11'd1;
  assign w_bad = x_inc != HW;
  // a line ending on the same cycle as the frame edge belongs to the frame being judged
  assign h_fin = de_fall ? l_inc : line_cnt;
  assign bad = frame_bad || (de_fall && w_bad) || h_fin != VH || !(hs_seen || hs_a2);
  assign pix_ok = state == LOCKED && blk2 && x_cnt < HW && line_cnt < VH;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) {hs1, hs2, vs1, vs2, blk1, blk2, rgb1, rgb2} <= '0;
    else {hs1, hs2, vs1, vs2, blk1, blk2, rgb1, rgb2} <= {VGA_HS, hs1, VGA_VS, vs1, VGA_BLK, blk1, VGA_RGB, rgb1};
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      x_cnt <= '0;
      line_cnt <= '0;
      Meas_Width <= '0;
      Meas_Height <= '0;
      frame_bad <= 1'b0;
      hs_seen <= 1'b0;
    end else begin
      if (de_fall) begin
        x_cnt <= '0;
        Meas_Width <= x_inc;
      end else if (blk2) x_cnt <= x_inc;
      if (vs_rise) begin
        line_cnt <= '0;
        Meas_Height <= h_fin;
        frame_bad <= 1'b0;
        hs_seen <= 1'b0;
      end else begin
        if (de_fall) line_cnt <= l_inc;
        if (de_fall && w_bad) frame_bad <= 1'b1;
        if (hs_a2) hs_seen <= 1'b1;
      end
    end
  always_comb begin
    state_n = state;
    good_n = good;
    if (vs_rise) begin
      if (state == SEARCH) begin
        state_n = CHECK;
        good_n = '0;
      end else if (state == CHECK) begin
        good_n = bad ? 3'd0 : good + 3'd1;
        state_n = !bad && good + 3'd1 == LF ? LOCKED : CHECK;
      end else if (bad) state_n = SEARCH;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= SEARCH;
      good <= '0;
      Locked <= 1'b0;
      Err <= 1'b0;
      Pix_Valid <= 1'b0;
      Frame_Start <= 1'b0;
      Frame_End <= 1'b0;
      Pix_Data <= '0;
      Pix_X <= '0;
      Pix_Y <= '0;
    end else begin
      state <= state_n;
      good <= good_n;
      Locked <= state_n == LOCKED;
      Err <= state == LOCKED && state_n == SEARCH;
      Pix_Valid <= pix_ok;
      Frame_Start <= pix_ok && x_cnt == 11'd0 && line_cnt == 11'd0;
      Frame_End <= pix_ok && x_cnt == HW - 11'd1 && line_cnt == VH - 11'd1;
      if (pix_ok) {Pix_Data, Pix_X, Pix_Y} <= {rgb2, x_cnt, line_cnt};
    end
endmodule

// File: tb/tb_vga_rx_capture.sv
// tb_vga_rx_capture: directed bench for vga_rx_capture on a scaled 16x8 format
module tb_vga_rx_capture;
  localparam int W = 16;
  localparam int V = 8;
  logic Clk = 1'b0, Reset_n = 1'b0, VGA_HS = 1'b1, VGA_VS = 1'b1, VGA_BLK = 1'b0;
  logic [23:0] VGA_RGB = '0;
  logic Pix_Valid, Frame_Start, Frame_End, Locked, Err;
  logic [23:0] Pix_Data;
  logic [10:0] Pix_X, Pix_Y, Meas_Width, Meas_Height;
  vga_rx_capture #(.H_ACT(W), .V_ACT(V), .LOCK_FRAMES(2), .HS_POL(1'b0), .VS_POL(1'b0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLK(VGA_BLK),
    .VGA_RGB(VGA_RGB), .Pix_Valid(Pix_Valid), .Pix_Data(Pix_Data), .Pix_X(Pix_X), .Pix_Y(Pix_Y),
    .Frame_Start(Frame_Start), .Frame_End(Frame_End), .Locked(Locked),
    .Meas_Width(Meas_Width), .Meas_Height(Meas_Height), .Err(Err)
  );
  always #5 Clk = ~Clk;
  int n_tests = 0, n_fail = 0;
  int n_valid = 0, n_seq = 0, n_err = 0, n_lock = 0, n_fs = 0, n_fe = 0, ex = 0, ey = 0;
  int v0, s0, fs0, fe0, e0, l0;
  logic [5:0] vsd = '0;
  logic [23:0] c00 = '1, c10 = '0, c01 = '0, cll = '0;
  logic fs00 = 1'b0, fell = 1'b0, lk1, lk2, er1, er2, rst_lk;
  logic [10:0] mw_short, rst_mw;
  function automatic logic [23:0] pat(input int x, input int y);
    logic [23:0] cols [8];
    cols = '{24'h000000, 24'h0000FF, 24'hFF0000, 24'h00FF00,
             24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'hFFFFFF};
    return cols[((y % V) / (V / 4)) * 2 + x / (W / 2)];
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // raster model restarts a few cycles after each VS edge, once the previous frame has drained
  always @(negedge Clk) begin
    vsd = {vsd[4:0], !VGA_VS};
    if (vsd[4] && !vsd[5]) begin
      ex = 0;
      ey = 0;
    end
    if (Err) n_err++;
    if (Locked) n_lock++;
    if (Frame_Start) n_fs++;
    if (Frame_End) n_fe++;
    if ((Frame_Start || Frame_End) && !Pix_Valid) n_seq++;
    if (Pix_Valid) begin
      n_valid++;
      if (Pix_X != 11'(ex) || Pix_Y != 11'(ey) || Pix_Data != pat(ex, ey) ||
          Frame_Start != (ex == 0 && ey == 0) || Frame_End != (ex == W - 1 && ey == V - 1)) n_seq++;
      if (Pix_X == 0 && Pix_Y == 0) begin
        c00 = Pix_Data;
        fs00 = Frame_Start;
      end
      if (Pix_X == W / 2 && Pix_Y == 0) c10 = Pix_Data;
      if (Pix_X == 0 && Pix_Y == V / 4) c01 = Pix_Data;
      if (Pix_X == W - 1 && Pix_Y == V - 1) begin
        cll = Pix_Data;
        fell = Frame_End;
      end
      ex++;
      if (ex == W) begin
        ex = 0;
        ey++;
      end
    end
  end
  task automatic step(input logic blk, input logic hs, input logic vs, input logic [23:0] rgb);
    @(posedge Clk);
    #1;
    VGA_BLK = blk;
    VGA_HS = hs;
    VGA_VS = vs;
    VGA_RGB = rgb;
  endtask
  task automatic act(input int y, input int w);
    for (int x = 0; x < w; x++) step(1'b1, 1'b1, 1'b1, pat(x, y));
  endtask
  task automatic hblank();
    step(1'b0, 1'b1, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 1'b1, '0);
  endtask
  task automatic vblank(input bit coinc);
    if (!coinc) begin
      step(1'b0, 1'b1, 1'b1, '0);
      step(1'b0, 1'b1, 1'b1, '0);
    end
    step(1'b0, 1'b1, 1'b0, '0);
    @(negedge Clk);
    @(negedge Clk);
    lk1 = Locked;
    er1 = Err;
    @(negedge Clk);
    lk2 = Locked;
    er2 = Err;
    repeat (4) step(1'b0, 1'b1, 1'b1, '0);
  endtask
  task automatic frame(input int nl, input int first = 0, input int short_row = -1,
                       input int rst_row = -1, input bit coinc = 1'b0);
    for (int y = first; y < nl; y++) begin
      if (y == rst_row) begin
        @(posedge Clk);
        #1 Reset_n = 1'b0;
        @(negedge Clk);
        rst_lk = Locked;
        rst_mw = Meas_Width;
        @(posedge Clk);
        #1 Reset_n = 1'b1;
      end
      act(y, y == short_row ? W - 1 : W);
      if (!(coinc && y == nl - 1)) hblank();
      if (y == short_row) mw_short = Meas_Width;
    end
    vblank(coinc);
  endtask
  task automatic pulse_reset();
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end
  initial begin
    for (int y = 0; y < 4; y++) begin
      act(y, W);
      hblank();
    end
    @(negedge Clk);
    check("rst_out", 32'(|{Pix_Valid, Pix_Data, Pix_X, Pix_Y, Frame_Start, Frame_End,
                           Locked, Meas_Width, Meas_Height, Err}), 0);
    fork
      begin
        repeat (5) @(posedge Clk);
        #2 Reset_n = 1'b1;
      end
      begin
        act(4, W);
        hblank();
      end
    join
    frame(V, 5);
    check("search_lock", Locked, 0);
    frame(V);
    check("check_lock", lk2, 0);
    frame(V);
    check("lock_pre", lk1, 0);
    check("lock_post", lk2, 1);
    check("prelock_valid", n_valid, 0);
    check("meas_w", Meas_Width, W);
    check("meas_h", Meas_Height, V);
    v0 = n_valid;
    s0 = n_seq;
    fs0 = n_fs;
    fe0 = n_fe;
    frame(V);
    check("valid_cnt", n_valid - v0, W * V);
    check("raster", n_seq - s0, 0);
    check("px_0_0", c00, 24'h000000);
    check("fs_0_0", fs00, 1);
    check("px_mid_0", c10, 24'h0000FF);
    check("px_0_q", c01, 24'hFF0000);
    check("px_last", cll, 24'hFFFFFF);
    check("fe_last", fell, 1);
    check("fs_count", n_fs - fs0, 1);
    check("fe_count", n_fe - fe0, 1);
    e0 = n_err;
    frame(V, 0, 3);
    check("short_w", mw_short, W - 1);
    check("err_early", er1, 0);
    check("err_pulse", er2, 1);
    check("lock_drop", lk2, 0);
    frame(V);
    check("err_once", n_err - e0, 1);
    frame(V);
    check("relock_early", lk2, 0);
    frame(V);
    check("relock", lk2, 1);
    pulse_reset();
    v0 = n_valid;
    l0 = n_lock;
    repeat (4) frame(V + 1);
    check("tall_h", Meas_Height, V + 1);
    check("tall_lock", n_lock - l0, 0);
    check("tall_valid", n_valid - v0, 0);
    pulse_reset();
    frame(V, 0, -1, -1, 1'b1);
    frame(V, 0, -1, -1, 1'b1);
    check("coinc_early", lk2, 0);
    frame(V, 0, -1, -1, 1'b1);
    check("coinc_lock", lk2, 1);
    check("coinc_h", Meas_Height, V);
    frame(V, 0, -1, V / 2);
    check("rst_lock", rst_lk, 0);
    check("rst_mw", rst_mw, 0);
    frame(V);
    check("rst_relock_early", lk2, 0);
    frame(V);
    check("rst_relock", lk2, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_rx_capture.md
Name: vga_rx_capture

Overview:
- Receive side of the panel video interface: takes the HS/VS/BLK/RGB stream that the VGA/TFT controller drives and recovers a pixel stream with X/Y coordinates.
- Measures active width and height, and locks once the format matches the expected 800x480 timing.
- Used on the loopback test board to check the display path and to feed captured frames to the frame-buffer writer.

Parameters:
- H_ACT, 800, expected active pixels per line (BLK-high cycles per line).
- V_ACT, 480, expected active lines per frame.
- LOCK_FRAMES, 2, consecutive matching frames required to lock (1..7).
- HS_POL, 0, HS active level (0 = active-low).
- VS_POL, 0, VS active level (0 = active-low).

Ports:
- Clk  in  1  pixel clock; input stream is synchronous to it.
- Reset_n  in  1  asynchronous active-low reset.
- VGA_HS  in  1  line sync.
- VGA_VS  in  1  frame sync.
- VGA_BLK  in  1  data-enable; high = active pixel.
- VGA_RGB  in  24  pixel, RGB888 (RGB565 sources zero-padded).
- Pix_Valid  out  1  captured pixel valid.
- Pix_Data  out  24  captured pixel.
- Pix_X  out  11  column of Pix_Data, 0..H_ACT-1.
- Pix_Y  out  11  row of Pix_Data, 0..V_ACT-1.
- Frame_Start  out  1  one-cycle pulse with pixel (0,0).
- Frame_End  out  1  one-cycle pulse with pixel (H_ACT-1,V_ACT-1).
- Locked  out  1  format lock status.
- Meas_Width  out  11  BLK-high count of the last completed line.
- Meas_Height  out  11  active-line count of the last completed frame.
- Err  out  1  one-cycle pulse when lock is lost.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM goes to SEARCH; all counters and flags clear.
  - An asserted reset mid-frame aborts immediately; there is no partial-frame state afterwards.
- Input stage:
  - All inputs are registered twice (s1, s2).
  - vs_rise = VS active in s1 and inactive in s2.
  - de_fall = BLK low in s1 and high in s2.
  - HS is used only for the polarity-checked sync-present flag and does not gate capture.
- Counters:
  - x_cnt: +1 on each s2 BLK-high cycle; cleared on de_fall.
  - line_cnt: +1 on de_fall; cleared on vs_rise.
  - Both saturate at 2047 and never wrap.
  - On de_fall: Meas_Width <= x_cnt+1 (count including the final pixel). If that value != H_ACT, set frame_bad.
  - On vs_rise: Meas_Height <= line_cnt. If that value != V_ACT, the frame counts as bad.
  - frame_bad clears on vs_rise after it is evaluated.
  - If vs_rise and de_fall fall on the same cycle, the line end is applied first, then the frame is evaluated with that line included.
- FSM:
  - SEARCH: on vs_rise, go to CHECK with good=0. No frame is evaluated on this edge (the preceding frame was partial).
  - CHECK: on each vs_rise:
    - Frame good: good+1. If the new good == LOCK_FRAMES, go to LOCKED.
    - Frame bad: good=0 and stay in CHECK.
  - LOCKED: on vs_rise with a bad frame, go to SEARCH and pulse Err for 1 cycle.
  - Locked = (state == LOCKED), registered. It rises in the cycle after the locking vs_rise and falls together with the Err pulse.
- Output:
  - In LOCKED, every s2 BLK-high cycle produces one output cycle:
    - Pix_Valid=1.
    - Pix_Data = s2 RGB.
    - Pix_X = x_cnt, Pix_Y = line_cnt.
  - Latency is 3 Clk cycles from input pin to output.
  - Pix_Valid is 0 for pixels with x_cnt >= H_ACT or line_cnt >= V_ACT. Out-of-range coordinates are never emitted.
  - Frame_Start pulses with Pix_Valid when X=0, Y=0. Frame_End pulses with Pix_Valid when X=H_ACT-1, Y=V_ACT-1.
  - Outside LOCKED: Pix_Valid, Frame_Start and Frame_End are 0. Pix_Data, Pix_X and Pix_Y hold their last values.
- The frame in progress when lock is achieved starts from its first pixel, because lock changes only on vs_rise.

Test Plan:
- Reset: hold Reset_n=0 with active stream toggling -> all outputs 0. Release mid-line -> Locked=0 and no Pix_Valid until lock is reached.
- Nominal lock: drive an 800x480 stream carrying the 8-block colour pattern (4 rows x 2 columns; block (0,0) 0x000000, (0,1) 0x0000FF, (1,0) 0xFF0000, (3,1) 0xFFFFFF) from mid-frame -> Locked rises 1 cycle after the 3rd vs_rise.
  - Next frame: (0,0)=0x000000 with Frame_Start, (400,0)=0x0000FF, (0,120)=0xFF0000, (799,479)=0xFFFFFF with Frame_End.
  - Exactly 384000 Pix_Valid cycles per frame; Meas_Width=800, Meas_Height=480.
- Short line while locked: one line with 799 BLK cycles -> Meas_Width=799 after that line; Err pulses once at the next vs_rise and Locked falls the same cycle. Then 2 clean frames after the next vs_rise -> relock.
- Wrong height: 481-line frames -> never locks; Meas_Height=481; Pix_Valid stays 0.
- Coincident edges: BLK falls in the same cycle VS asserts on the last line -> line is counted, Meas_Height=480, frame judged good.
- Reset mid-frame while locked: Reset_n pulse at line 200 -> Locked=0 immediately; relocks after the 3rd subsequent vs_rise.
